coeff_loader: RTL and testbench

COEFF_LOADER -- requirements
Module: coeff_loader

---
 rtl/coeff_loader_pkg.sv | 14 +
 rtl/coeff_reg.sv | 30 +++
 rtl/coeff_loader.sv | 104 ++++++++++
 tb/tb_coeff_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/coeff_loader_pkg.sv
// Shared FIR definitions: default tap count, coefficient width and the
// loader state encoding used by coeff_loader and FIR_filter.
package coeff_loader_pkg;

    localparam int unsigned FIR_N_TAPS = 9;
    localparam int unsigned FIR_NB     = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } fir_state_e;

endpackage : coeff_loader_pkg

// File: rtl/coeff_reg.sv
// One coefficient tap: a shadow word written during loading and an active
// word that takes the shadow value only on commit.
module coeff_reg #(
    parameter int unsigned NB = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [NB-1:0] wr_data,
    input  logic          commit,
    output logic [NB-1:0] active
);

    logic [NB-1:0] shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (wr_en) begin
                shadow <= wr_data;
            end
            if (commit) begin
                active <= shadow;
            end
        end
    end

endmodule : coeff_reg

// File: rtl/coeff_loader.sv
// Loads N_TAPS coefficient words into a shadow set and atomically commits
// them to the active Coeffs bus that feeds FIR_filter.
module coeff_loader
    import coeff_loader_pkg::*;
#(
    parameter int unsigned N_TAPS = FIR_N_TAPS,
    parameter int unsigned NB     = FIR_NB
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 LOAD_START,
    input  logic [NB-1:0]        COEF_IN,
    input  logic                 COEF_VIN,
    input  logic                 COMMIT,
    output logic [N_TAPS*NB-1:0] Coeffs,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR
);

    localparam int unsigned   CW   = $clog2(N_TAPS + 1);
    localparam logic [CW-1:0] LAST = CW'(N_TAPS - 1);

    fir_state_e    state;
    logic [CW-1:0] count;
    logic          at_last_c;
    logic          accept_c;
    logic          commit_c;

    // A commit in LOAD aborts the set, except when it coincides with the
    // final word, which is still taken so the set reaches FULL.
    always_comb begin
        at_last_c = (count == LAST);
        accept_c  = (state == LOAD) && COEF_VIN && !LOAD_START
                    && (!COMMIT || at_last_c);
        commit_c  = (state == FULL) && COMMIT && !LOAD_START;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
            count <= '0;
            ERR   <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (LOAD_START) begin
                state <= LOAD;
                count <= '0;
                ERR   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (COEF_VIN || COMMIT) begin
                            ERR <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (accept_c) begin
                            count <= count + CW'(1);
                            if (at_last_c) begin
                                state <= FULL;
                            end
                        end
                        if (COMMIT) begin
                            ERR <= 1'b1;
                            if (!accept_c) begin
                                state <= IDLE;
                            end
                        end
                    end
                    FULL: begin
                        if (COEF_VIN) begin
                            ERR <= 1'b1;
                        end
                        if (COMMIT) begin
                            state <= IDLE;
                            DONE  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign BUSY = (state != IDLE);

    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
        coeff_reg #(
            .NB(NB)
        ) u_reg (
            .clk    (CLK),
            .rst_n  (RST_n),
            .wr_en  (accept_c && (count == CW'(k))),
            .wr_data(COEF_IN),
            .commit (commit_c),
            .active (Coeffs[k*NB +: NB])
        );
    end

endmodule : coeff_loader

// File: tb/tb_coeff_loader.sv
// Directed, table-driven bench for coeff_loader with hand-computed expectations.
module tb_coeff_loader;

    localparam int unsigned NT = 9;
    localparam int unsigned W  = 9;
    localparam int unsigned BW = NT * W;

    logic          clk;
    logic          rst_n;
    logic          load_start;
    logic [W-1:0]  coef_in;
    logic          coef_vin;
    logic          commit;
    logic [BW-1:0] coeffs;
    logic          busy;
    logic          done;
    logic          err;

    int checks;
    int failures;

    typedef struct {
        logic          ls;
        logic          vin;
        logic [W-1:0]  din;
        logic          cm;
        logic          busy;
        logic          done;
        logic          err;
        logic [BW-1:0] coeffs;
    } vec_t;

    vec_t          tbl[$];
    logic [BW-1:0] cur;

    coeff_loader #(
        .N_TAPS(NT),
        .NB    (W)
    ) dut (
        .CLK       (clk),
        .RST_n     (rst_n),
        .LOAD_START(load_start),
        .COEF_IN   (coef_in),
        .COEF_VIN  (coef_vin),
        .COMMIT    (commit),
        .Coeffs    (coeffs),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] mk_set(input int first);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < NT; k++) begin
            r[k*W +: W] = W'(first + k);
        end
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic ls, input logic vin, input logic [W-1:0] din,
                       input logic cm, input logic b, input logic d, input logic e);
        vec_t v;
        v.ls     = ls;
        v.vin    = vin;
        v.din    = din;
        v.cm     = cm;
        v.busy   = b;
        v.done   = d;
        v.err    = e;
        v.coeffs = cur;
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic ls, input logic vin, input logic [W-1:0] din, input logic cm);
        @(negedge clk);
        load_start = ls;
        coef_vin   = vin;
        coef_in    = din;
        commit     = cm;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input int base);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ls, tbl[i].vin, tbl[i].din, tbl[i].cm);
            chk("busy",   base + i, BW'(busy), BW'(tbl[i].busy));
            chk("done",   base + i, BW'(done), BW'(tbl[i].done));
            chk("err",    base + i, BW'(err),  BW'(tbl[i].err));
            chk("coeffs", base + i, coeffs,    tbl[i].coeffs);
        end
        tbl.delete();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cur        = '0;
        rst_n      = 1'b0;
        load_start = 1'b0;
        coef_vin   = 1'b0;
        coef_in    = '0;
        commit     = 1'b0;

        #2;
        chk("rst_coeffs", 0, coeffs, '0);
        chk("rst_flags",  0, BW'({busy, done, err}), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);

        // Normal load of 1..9 and commit
        add(1, 0, '0, 0, 1, 0, 0);
        for (int i = 1; i <= 9; i++) add(0, 1, W'(i), 0, 1, 0, 0);
        cur = mk_set(1);
        add(0, 0, '0, 1, 0, 1, 0);
        add(0, 0, '0, 0, 0, 0, 0);
        // Stray word in IDLE
        add(0, 1, 9'h055, 0, 0, 0, 1);
        // Early commit after 5 words
        add(1, 0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, W'(11 + i), 0, 1, 0, 0);
        add(0, 0, '0, 1, 0, 0, 1);
        add(0, 0, '0, 0, 0, 0, 1);
        // Overflow: tenth word ignored, flagged
        add(1, 0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 1, W'(21 + i), 0, 1, 0, 0);
        add(0, 1, 9'h1FF, 0, 1, 0, 1);
        cur = mk_set(21);
        add(0, 0, '0, 1, 0, 1, 1);
        add(0, 0, '0, 0, 0, 0, 1);
        // Restart with negative set; first LOAD_START carries ignored VIN and COMMIT
        add(1, 1, 9'h0AA, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 1, W'(5 + i), 0, 1, 0, 0);
        add(1, 0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 1, W'(-100 + i), 0, 1, 0, 0);
        cur = mk_set(-100);
        add(0, 0, '0, 1, 0, 1, 0);
        // Commit in LOAD aborts to IDLE; further word is a stray
        add(1, 0, '0, 0, 1, 0, 0);
        add(0, 1, W'(1), 0, 1, 0, 0);
        add(0, 0, '0, 1, 0, 0, 1);
        add(0, 1, W'(2), 0, 0, 0, 1);
        // Final word together with COMMIT: accepted, flagged, no commit
        add(1, 1, 9'h0AA, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 1, W'(31 + i), 0, 1, 0, 0);
        add(0, 1, W'(39), 1, 1, 0, 1);
        cur = mk_set(31);
        add(0, 0, '0, 1, 0, 1, 1);
        add(0, 0, '0, 0, 0, 0, 1);
        run_table(100);

        // Reset in the middle of a new load
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, W'(50 + i), 1'b0);
        chk("midload_coeffs", 1, coeffs, mk_set(31));
        chk("midload_busy",   1, BW'(busy), BW'(1'b1));
        @(negedge clk);
        load_start = 1'b0;
        coef_vin   = 1'b0;
        commit     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_coeffs", 2, coeffs, '0);
        chk("async_rst_flags",  2, BW'({busy, done, err}), '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);

        // After reset: commit in IDLE, then a fresh full load
        cur = '0;
        add(0, 0, '0, 1, 0, 0, 1);
        add(1, 0, '0, 0, 1, 0, 0);
        for (int i = 0; i < 9; i++) add(0, 1, W'(41 + i), 0, 1, 0, 0);
        cur = mk_set(41);
        add(0, 0, '0, 1, 0, 1, 0);
        add(0, 0, '0, 0, 0, 0, 0);
        run_table(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_coeff_loader
